// File: rtl/gray_hamming_tx.sv
// Serial transmitter: converts a 4-bit value to Gray code, wraps it in a Hamming(7,4)
// codeword and shifts it out LSB-first between a low start bit and a high stop bit.
module gray_hamming_tx #(
    parameter int unsigned CLKS_PER_BIT = 2700
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       tx_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [6:0] code_o
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [6:0]      code_q, code_d;
    logic            tx_q, tx_d;

    logic [3:0] gray;
    logic [6:0] code_new;
    logic       accept;
    logic       bit_end;

    // code = {d4, d3, d2, p3, d1, p2, p1} with d1..d4 = gray[0..3], even parity
    always_comb begin
        gray     = data_i ^ (data_i >> 1);
        code_new = {gray[3], gray[2], gray[1], gray[1] ^ gray[2] ^ gray[3],
                    gray[0], gray[0] ^ gray[2] ^ gray[3], gray[0] ^ gray[1] ^ gray[3]};
    end

    assign accept  = (state_q == StIdle) && valid_i;
    assign bit_end = (cnt_q == CntMax);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        code_d  = code_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (accept) begin
                    state_d = StStart;
                    code_d  = code_new;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == 3'd6) begin
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStop: begin
                if (bit_end) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Line level is computed from the next state so tx_q lines up with the state register
        tx_d = 1'b1;
        unique case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = code_d[idx_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            code_q  <= 7'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            code_q  <= code_d;
            tx_q    <= tx_d;
        end
    end

    assign ready_o = (state_q == StIdle);
    assign busy_o  = (state_q != StIdle);
    assign done_o  = (state_q == StStop) && bit_end;
    assign tx_o    = tx_q;
    assign code_o  = code_q;

endmodule

// File: tb/tb_gray_hamming_tx.sv
// Self-checking bench for gray_hamming_tx: directed frames, reset cases, exhaustive and
// randomized sends, each compared with a position-based Hamming model and a line receiver.
module tb_gray_hamming_tx;

    localparam int C = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] data_i;
    logic       valid_i;
    logic       ready_o;
    logic       tx_o;
    logic       busy_o;
    logic       done_o;
    logic [6:0] code_o;

    int checks = 0;
    int errors = 0;

    gray_hamming_tx #(
        .CLKS_PER_BIT(C)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .data_i (data_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .tx_o   (tx_o),
        .busy_o (busy_o),
        .done_o (done_o),
        .code_o (code_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hamming positions 1..7: powers of two carry parity, the rest carry Gray bits in order
    function automatic logic [6:0] model_code(input int b);
        int         g;
        int         d;
        logic [7:0] cw;
        g  = b ^ (b >> 1);
        cw = '0;
        d  = 0;
        for (int q = 1; q <= 7; q++) begin
            if ((q & (q - 1)) != 0) begin
                cw[q] = 1'((g >> d) & 1);
                d++;
            end
        end
        for (int p = 1; p <= 4; p = p * 2) begin
            for (int q = 3; q <= 7; q++) begin
                if (((q & (q - 1)) != 0) && ((q & p) != 0)) cw[p] = cw[p] ^ cw[q];
            end
        end
        return cw[7:1];
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge of the first post-frame cycle
    task automatic send_frame(input logic [3:0] b, input bit hold, input bit poke);
        logic [6:0] exp_code;
        logic [6:0] rx;
        logic       exp_tx;
        logic [3:0] g;
        logic [3:0] bin;
        int         slot;
        int         syn;
        exp_code = model_code(int'(b));
        rx       = '0;
        chk("accept_ready", 32'(ready_o), 32'(1'b1));
        data_i  = b;
        valid_i = 1'b1;
        for (int k = 1; k <= 9 * C; k++) begin
            @(negedge clk);
            if (!hold) begin
                valid_i = (poke && (k == 3 * C)) ? 1'b1 : 1'b0;
                if (poke) data_i = ~b;
            end
            slot   = (k - 1) / C;
            exp_tx = (slot == 0) ? 1'b0 : (slot == 8) ? 1'b1 : exp_code[slot - 1];
            chk($sformatf("tx k=%0d", k), 32'(tx_o), 32'(exp_tx));
            chk($sformatf("busy k=%0d", k), 32'(busy_o), 32'(1'b1));
            chk($sformatf("ready k=%0d", k), 32'(ready_o), 32'(1'b0));
            chk($sformatf("done k=%0d", k), 32'(done_o), 32'(k == 9 * C));
            chk($sformatf("code k=%0d", k), 32'(code_o), 32'(exp_code));
            if (((k - 1) % C == C / 2) && slot >= 1 && slot <= 7) rx[slot - 1] = tx_o;
        end
        @(negedge clk);
        chk("post_ready", 32'(ready_o), 32'(1'b1));
        chk("post_busy", 32'(busy_o), 32'(1'b0));
        chk("post_tx", 32'(tx_o), 32'(1'b1));
        chk("post_done", 32'(done_o), 32'(1'b0));
        chk("post_code", 32'(code_o), 32'(exp_code));
        syn = 0;
        for (int p = 1; p <= 7; p++) begin
            if (rx[p - 1]) syn = syn ^ p;
        end
        chk("syndrome", 32'(syn), 32'(0));
        g      = {rx[6], rx[5], rx[4], rx[2]};
        bin[3] = g[3];
        for (int i = 2; i >= 0; i--) bin[i] = bin[i + 1] ^ g[i];
        chk("gray2bin", 32'(bin), 32'(b));
    endtask

    initial begin
        // Reset with valid_i high: nothing may be accepted
        rst_n   = 1'b0;
        valid_i = 1'b1;
        data_i  = 4'b0101;
        repeat (3) begin
            @(negedge clk);
            chk("rst_tx", 32'(tx_o), 32'(1'b1));
            chk("rst_ready", 32'(ready_o), 32'(1'b1));
            chk("rst_busy", 32'(busy_o), 32'(1'b0));
            chk("rst_done", 32'(done_o), 32'(1'b0));
            chk("rst_code", 32'(code_o), 32'(0));
        end
        rst_n   = 1'b1;
        valid_i = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("idle_tx", 32'(tx_o), 32'(1'b1));
            chk("idle_ready", 32'(ready_o), 32'(1'b1));
            chk("idle_busy", 32'(busy_o), 32'(1'b0));
            chk("idle_code", 32'(code_o), 32'(0));
        end

        send_frame(4'b0101, 1'b0, 1'b0);
        chk("code_0101", 32'(code_o), 32'(7'h34));
        send_frame(4'b1111, 1'b0, 1'b0);
        chk("code_1111", 32'(code_o), 32'(7'h4B));

        // Back-to-back with valid held: one ready cycle between frames
        send_frame(4'b0000, 1'b1, 1'b0);
        send_frame(4'b0000, 1'b0, 1'b0);
        chk("code_0000", 32'(code_o), 32'(7'h00));

        // valid pulse with other data while busy must be dropped
        send_frame(4'b1001, 1'b0, 1'b1);
        repeat (2) begin
            @(negedge clk);
            chk("drop_idle", 32'(busy_o), 32'(1'b0));
        end

        // Reset during data bit 3
        data_i  = 4'b0110;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (17) @(negedge clk);
        chk("pre_rst_busy", 32'(busy_o), 32'(1'b1));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_tx", 32'(tx_o), 32'(1'b1));
        chk("mid_rst_ready", 32'(ready_o), 32'(1'b1));
        chk("mid_rst_busy", 32'(busy_o), 32'(1'b0));
        chk("mid_rst_done", 32'(done_o), 32'(1'b0));
        chk("mid_rst_code", 32'(code_o), 32'(0));
        repeat (9 * C) begin
            @(negedge clk);
            chk("after_rst_done", 32'(done_o), 32'(1'b0));
            chk("after_rst_tx", 32'(tx_o), 32'(1'b1));
        end
        send_frame(4'b0110, 1'b0, 1'b0);

        // All 16 values, random idle gaps
        for (int v = 0; v < 16; v++) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                chk("gap_ready", 32'(ready_o), 32'(1'b1));
            end
            send_frame(4'(v), 1'b0, 1'b0);
        end

        // Random values with optional busy-time valid pulses
        repeat (12) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_frame(4'($urandom_range(0, 15)), 1'b0, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
